// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// State encoding, default cycle counts and the saturating failure counter helper.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65535;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_CNT_W          = 16;

    localparam logic [7:0] FAIL_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == FAIL_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reset value is a parameter so the idle level of the source can be matched.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a qualified lock, then releases system reset.
// Runs on the board reference clock; re-resets the PLL on timeout, lock loss or request.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       pll_ok,
    output logic       timeout_err,
    output logic [7:0] fail_count,
    output logic [1:0] o_dbg_state
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic w_lock_s;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_reset;
    logic             r_sys_rst_n;
    logic             r_pll_ok;
    logic             r_timeout_err;
    logic [7:0]       r_fail_count;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    // Outputs are assigned together with each transition so they track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PLL_RST;
            r_cnt         <= '0;
            r_pll_reset   <= 1'b1;
            r_sys_rst_n   <= 1'b0;
            r_pll_ok      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_fail_count  <= '0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state     <= WAIT_LOCK;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    // A timeout wins over a coincident request so the error is still recorded.
                    if (!w_lock_s && r_cnt == TO_LAST) begin
                        r_state       <= PLL_RST;
                        r_cnt         <= '0;
                        r_pll_reset   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_fail_count  <= sat_inc(r_fail_count);
                    end else if (force_relock) begin
                        r_state     <= PLL_RST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                    end else if (w_lock_s) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                STABLE: begin
                    if (force_relock) begin
                        r_state     <= PLL_RST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                    end else if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == ST_LAST) begin
                        r_state     <= RUN;
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_pll_ok    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!w_lock_s || force_relock) begin
                        r_state     <= PLL_RST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        r_sys_rst_n <= 1'b0;
                        r_pll_ok    <= 1'b0;
                        if (!w_lock_s) begin
                            r_fail_count <= sat_inc(r_fail_count);
                        end
                    end
                end
                default: begin
                    r_state     <= PLL_RST;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    r_pll_ok    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset   = r_pll_reset;
    assign sys_rst_n   = r_sys_rst_n;
    assign pll_ok      = r_pll_ok;
    assign timeout_err = r_timeout_err;
    assign fail_count  = r_fail_count;
    assign o_dbg_state = r_state;

endmodule
